// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction-RAM arbiter.
// State encoding, latency bounds and packed-bus slicing.
package imem_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 3;
    localparam int SLICE_MAXW = 64;
    localparam int SLICE_BUSW = 8 * SLICE_MAXW;

    function automatic bit lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // Returns slice idx of width w from a zero-extended packed bus.
    function automatic logic [SLICE_MAXW-1:0] get_slice(
        input logic [SLICE_BUSW-1:0] bus,
        input int                    idx,
        input int                    w
    );
        logic [SLICE_BUSW-1:0] sh;
        sh = bus >> (idx * w);
        return sh[SLICE_MAXW-1:0];
    endfunction

endpackage

// File: rtl/imem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Winner is the first set request after 'last', wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    // Scan farthest-to-nearest so the nearest requester wins.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            j = (int'(last) + i) % N;
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter of NCORES fetch ports
// onto a single-port instruction RAM with fixed read latency.
module imem_arbiter #(
    parameter int NCORES  = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RAM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] din,
    input  logic [DW-1:0]        RAMq,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren
);
    import imem_pkg::*;

    localparam int IW = $clog2(NCORES);

    if (!lat_ok(RAM_LAT)) begin : g_lat_chk
        $error("imem_arbiter: RAM_LAT must be 1..3");
    end

    state_t                state;
    logic [IW-1:0]         last;
    logic [IW-1:0]         owner;
    logic [1:0]            cnt;
    logic [NCORES-1:0]     win_oh;
    logic [IW-1:0]         win_idx;
    logic [SLICE_BUSW-1:0] addr_x;
    logic [SLICE_BUSW-1:0] din_x;

    assign addr_x = SLICE_BUSW'(addr);
    assign din_x  = SLICE_BUSW'(din);

    rr_pick #(
        .N  (NCORES),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last),
        .onehot (win_oh),
        .idx    (win_idx)
    );

    // Grant in IDLE, wait out the RAM latency in BUSY, then acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            ack        <= '0;
            rdata      <= '0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
            last       <= IW'(NCORES - 1);
            owner      <= '0;
            cnt        <= '0;
        end else begin
            gnt     <= '0;
            ack     <= '0;
            RAMwren <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        RAMAddress <= AW'(get_slice(addr_x, int'(win_idx), AW));
                        RAMDin     <= DW'(get_slice(din_x, int'(win_idx), DW));
                        RAMwren    <= wren[win_idx];
                        gnt        <= win_oh;
                        owner      <= win_idx;
                        last       <= win_idx;
                        cnt        <= 2'(RAM_LAT);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 2'd0) begin
                        rdata      <= RAMq;
                        ack[owner] <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of imem_arbiter
// against a transaction-level schedule model.
module tb_imem_arbiter;

    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int MAXC = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req, wren, gnt, ack;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] din;
    logic [DW-1:0]   RAMq, rdata, RAMDin;
    logic [AW-1:0]   RAMAddress;
    logic            RAMwren;

    logic [N-1:0]    req3, wren3, gnt3, ack3;
    logic [N*AW-1:0] addr3;
    logic [N*DW-1:0] din3;
    logic [DW-1:0]   RAMq3, rdata3, RAMDin3;
    logic [AW-1:0]   RAMAddress3;
    logic            RAMwren3;

    imem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .RAM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .wren(wren), .addr(addr),
        .din(din), .RAMq(RAMq), .gnt(gnt), .ack(ack), .rdata(rdata),
        .RAMAddress(RAMAddress), .RAMDin(RAMDin), .RAMwren(RAMwren)
    );

    imem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .wren(wren3), .addr(addr3),
        .din(din3), .RAMq(RAMq3), .gnt(gnt3), .ack(ack3), .rdata(rdata3),
        .RAMAddress(RAMAddress3), .RAMDin(RAMDin3), .RAMwren(RAMwren3)
    );

    // RAM models: latency 1 and latency 3
    logic [7:0] mem  [256];
    logic [7:0] gmem [256];
    logic [7:0] mem3 [256];
    logic [7:0] p1, p2;

    always @(posedge clk) begin
        if (RAMwren) mem[RAMAddress] <= RAMDin;
        RAMq <= mem[RAMAddress];
    end

    always @(posedge clk) begin
        p1    <= mem3[RAMAddress3];
        p2    <= p1;
        RAMq3 <= p2;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected-output schedule, indexed by cycle number
    bit [N-1:0] e_gnt   [MAXC];
    bit [N-1:0] e_ack   [MAXC];
    bit         e_wren  [MAXC];
    bit         e_hold  [MAXC];
    bit         e_rd    [MAXC];
    bit [7:0]   e_addr  [MAXC];
    bit [7:0]   e_din   [MAXC];
    bit [7:0]   e_rdata [MAXC];

    int free_at = 0;
    int last_m  = N - 1;

    // Compare current outputs, then schedule the access decided this cycle.
    always @(negedge clk) begin : model
        int c, w, a, d;
        c = cyc;
        w = -1;
        chk("gnt", gnt, e_gnt[c]);
        chk("ack", ack, e_ack[c]);
        chk("wren", RAMwren, e_wren[c]);
        if (e_hold[c]) begin
            chk("ramaddr", RAMAddress, e_addr[c]);
            chk("ramdin", RAMDin, e_din[c]);
        end
        if (e_rd[c]) chk("rdata", rdata, e_rdata[c]);
        if (rst) begin
            for (int i = c + 1; i < c + 8; i++) begin
                e_gnt[i] = '0; e_ack[i] = '0; e_wren[i] = 0;
                e_hold[i] = 0; e_rd[i] = 0;
            end
            free_at = c + 1;
            last_m  = N - 1;
        end else if (c >= free_at && req != '0) begin
            for (int i = 1; i <= N; i++)
                if (w < 0 && req[(last_m + i) % N]) w = (last_m + i) % N;
            a = int'(addr[w*AW +: AW]);
            d = int'(din[w*DW +: DW]);
            last_m  = w;
            free_at = c + 2 + LAT;
            e_gnt[c+1]  = 4'(1) << w;
            e_wren[c+1] = wren[w];
            for (int t = c + 1; t <= c + 1 + LAT; t++) begin
                e_hold[t] = 1; e_addr[t] = 8'(a); e_din[t] = 8'(d);
            end
            e_ack[c+2+LAT] = 4'(1) << w;
            if (wren[w]) begin
                gmem[8'(a)] = 8'(d);
            end else begin
                e_rd[c+2+LAT]    = 1;
                e_rdata[c+2+LAT] = gmem[8'(a)];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [7:0] a,
                         input logic [7:0] d, input logic w);
        addr[k*AW +: AW] = a;
        din[k*DW +: DW]  = d;
        wren[k]          = w;
        req[k]           = 1'b1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        mem[a]  = v;
        gmem[a] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int k, output int at);
        k  = -1;
        at = -1;
        for (int i = 0; i < 20 && k < 0; i++) begin
            tick();
            if (gnt != '0) begin
                at = cyc;
                for (int j = 0; j < N; j++) if (gnt[j]) k = j;
            end
        end
        if (k < 0) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout cyc=%0d got=none want=grant", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, at, pk, pat;
        bit [N-1:0] pg;
        int exp_ord [5];
        exp_ord = '{0, 1, 2, 3, 0};

        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'(i * 37 + 11);
            gmem[i] = mem[i];
            mem3[i] = 8'(i) ^ 8'hC3;
        end
        preload(8'h15, 8'hA7);
        for (int i = 0; i < N; i++) preload(8'(8'h80 + i), 8'(8'h50 + i));
        mem3[8'h33] = 8'h5E;
        req = '0; wren = '0; addr = '0; din = '0;
        req3 = '0; wren3 = '0; addr3 = '0; din3 = '0;

        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", RAMAddress, 0);
        chk("rst_din", RAMDin, 0);
        chk("rst_wren", RAMwren, 0);
        chk("rst_gnt3", gnt3, 0);
        rst = 1'b0;

        // single read by core 2
        tick();
        drive(2, 8'h15, 8'h00, 1'b0);
        tick();
        chk("rd_gnt", gnt, 4'b0100);
        chk("rd_addr", RAMAddress, 8'h15);
        tick();
        req[2] = 1'b0;
        chk("rd_ack_early", ack, 0);
        tick();
        chk("rd_ack", ack, 4'b0100);
        chk("rd_data", rdata, 8'hA7);

        // write by core 1, read back by core 0
        tick();
        drive(1, 8'h40, 8'h3C, 1'b1);
        tick();
        chk("wr_gnt", gnt, 4'b0010);
        chk("wr_strobe", RAMwren, 1);
        chk("wr_din", RAMDin, 8'h3C);
        tick();
        req[1] = 1'b0;
        chk("wr_strobe_off", RAMwren, 0);
        tick();
        chk("wr_ack", ack, 4'b0010);
        drive(0, 8'h40, 8'h00, 1'b0);
        tick();
        chk("rb_gnt", gnt, 4'b0001);
        tick();
        req[0] = 1'b0;
        tick();
        chk("rb_ack", ack, 4'b0001);
        chk("rb_data", rdata, 8'h3C);

        // saturation from reset
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 8'(8'h80 + i), 8'h00, 1'b0);
        pat = -1;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(k, at);
            chk("sat_order", k, exp_ord[g]);
            if (pat >= 0) chk("sat_gap", at - pat, LAT + 2);
            pat = at;
        end
        req = '0;
        repeat (4) tick();

        // fairness from reset with req=0101
        do_reset();
        drive(0, 8'h90, 8'h00, 1'b0);
        drive(2, 8'h92, 8'h00, 1'b0);
        wait_gnt(k, at);
        chk("fair_1", k, 0);
        wait_gnt(k, at);
        chk("fair_2", k, 2);
        wait_gnt(k, at);
        chk("fair_3", k, 0);
        drive(1, 8'h91, 8'h00, 1'b0);
        wait_gnt(k, at);
        chk("fair_new1", k, 1);
        wait_gnt(k, at);
        chk("fair_5", k, 2);
        req = '0;
        repeat (4) tick();

        // reset during the grant cycle of a write
        do_reset();
        drive(3, 8'h22, 8'h99, 1'b1);
        tick();
        chk("mid_gnt", gnt, 4'b1000);
        chk("mid_wren", RAMwren, 1);
        rst = 1'b1;
        tick();
        req[3] = 1'b0;
        rst    = 1'b0;
        chk("mid_wren_off", RAMwren, 0);
        chk("mid_gnt_off", gnt, 0);
        chk("mid_addr", RAMAddress, 0);
        chk("mid_din", RAMDin, 0);
        chk("mid_rdata", rdata, 0);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("mid_noack", ack, 0);
        end

        // RAM_LAT=3 single read
        tick();
        addr3[AW-1:0] = 8'h33;
        req3[0]       = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (t == 2) req3[0] = 1'b0;
            if (t == 1) chk("lat3_gnt", gnt3, 4'b0001);
            if (t <= 4) begin
                chk("lat3_addr", RAMAddress3, 8'h33);
                chk("lat3_noack", ack3, 0);
            end else begin
                chk("lat3_ack", ack3, 4'b0001);
                chk("lat3_data", rdata3, 8'h5E);
            end
        end

        // random traffic with one reset midway
        pg = '0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            rst = (n == 700);
            for (int c = 0; c < N; c++) begin
                if (pg[c]) begin
                    if ($urandom_range(1, 0) == 0)
                        req[c] = 1'b0;
                    else
                        drive(c, 8'($urandom_range(15, 0)),
                              8'($urandom_range(255, 0)),
                              1'($urandom_range(1, 0)));
                end else if (!req[c] && $urandom_range(2, 0) == 0) begin
                    drive(c, 8'($urandom_range(15, 0)),
                          8'($urandom_range(255, 0)),
                          1'($urandom_range(1, 0)));
                end
            end
            pg = gnt;
        end
        rst = 1'b0;
        req = '0;
        repeat (8) tick();
        pk = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
